// File: rtl/noise_hist_pkg.sv
// Shared types and constants for the noise histogram OCM writer.
package noise_hist_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        DUMP  = 1'b1
    } state_t;

    localparam int NOISE_MIN     = -64;
    localparam int NOISE_MAX     = 63;
    localparam int BINS_PER_WORD = 4;
    localparam int FIELD_W       = 16;
    localparam int WORD_BITS     = BINS_PER_WORD * FIELD_W;

    function automatic logic in_range(input logic [7:0] v);
        return (int'($signed(v)) >= NOISE_MIN) && (int'($signed(v)) <= NOISE_MAX);
    endfunction

endpackage

// File: rtl/noise_hist_bank.sv
// NBINS saturating bin counters; one 64-bit word of four bins is read and
// cleared per cycle while dumping.
module noise_hist_bank
    import noise_hist_pkg::*;
#(
    parameter int NBINS  = 128,
    parameter int CNT_W  = 16,
    parameter int IDX_W  = $clog2(NBINS),
    parameter int WORD_W = $clog2(NBINS / BINS_PER_WORD)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 inc_en,
    input  logic [IDX_W-1:0]     inc_idx,
    input  logic                 clr_en,
    input  logic [WORD_W-1:0]    word_idx,
    output logic [WORD_BITS-1:0] rd_word
);

    localparam int NWORDS = NBINS / BINS_PER_WORD;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [NWORDS-1:0][WORD_BITS-1:0] words;

    for (genvar b = 0; b < NBINS; b++) begin : g_bin
        logic [CNT_W-1:0] cnt;
        logic             hit_clr;
        logic             hit_inc;

        assign hit_clr = clr_en && (word_idx == WORD_W'(b / BINS_PER_WORD));
        assign hit_inc = inc_en && (inc_idx == IDX_W'(b)) && (cnt != CNT_MAX);

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn)
                cnt <= '0;
            else if (hit_clr)
                cnt <= '0;
            else if (hit_inc)
                cnt <= cnt + 1'b1;
        end

        // Counters narrower than a field are zero-extended into it.
        assign words[b / BINS_PER_WORD][FIELD_W*(b % BINS_PER_WORD) +: FIELD_W] = FIELD_W'(cnt);
    end

    assign rd_word = words[word_idx];

endmodule

// File: rtl/noise_hist_ocm_writer.sv
// Histograms signed noise samples into NBINS bins and, on request, streams the
// packed bins to OCM one 64-bit word per cycle, clearing them as they go out.
module noise_hist_ocm_writer
    import noise_hist_pkg::*;
#(
    parameter int NBINS  = 128,
    parameter int CNT_W  = 16,
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              en,
    input  logic [7:0]        noise_in,
    input  logic              noise_in_valid,
    input  logic              dump_start,
    input  logic [ADDR_W-1:0] base_addr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic [63:0]       mem_writedata,
    output logic              busy,
    output logic              done,
    output logic              oor_flag,
    output logic              drop_flag
);

    localparam int NWORDS = NBINS / BINS_PER_WORD;
    localparam int IDX_W  = $clog2(NBINS);
    localparam int WORD_W = $clog2(NWORDS);
    localparam logic [7:0] NOISE_OFS = 8'(NOISE_MIN);

    state_t              state, state_nx;
    logic [WORD_W-1:0]   word_cnt;
    logic [ADDR_W-1:0]   base_q;
    logic [WORD_BITS-1:0] rd_word;

    logic sample;
    logic in_rng;
    logic dump_go;
    logic last_word;
    logic in_dump;

    assign sample    = en && noise_in_valid;
    assign in_rng    = in_range(noise_in);
    assign in_dump   = (state == DUMP);
    assign dump_go   = (state == ACCUM) && en && dump_start;
    assign last_word = (word_cnt == WORD_W'(NWORDS - 1));

    always_comb begin
        state_nx = state;
        case (state)
            ACCUM: if (dump_go)   state_nx = DUMP;
            DUMP:  if (last_word) state_nx = ACCUM;
            default:              state_nx = ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= ACCUM;
            word_cnt  <= '0;
            base_q    <= '0;
            done      <= 1'b0;
            oor_flag  <= 1'b0;
            drop_flag <= 1'b0;
        end else begin
            state    <= state_nx;
            done     <= in_dump && last_word;
            word_cnt <= (in_dump && !last_word) ? word_cnt + 1'b1 : '0;
            if (dump_go)
                base_q <= base_addr;
            // A dump request clears the flags even if the same-cycle sample would set one.
            if (dump_go)
                oor_flag <= 1'b0;
            else if (!in_dump && sample && !in_rng)
                oor_flag <= 1'b1;
            if (dump_go)
                drop_flag <= 1'b0;
            else if (in_dump && sample)
                drop_flag <= 1'b1;
        end
    end

    noise_hist_bank #(
        .NBINS (NBINS),
        .CNT_W (CNT_W),
        .IDX_W (IDX_W),
        .WORD_W(WORD_W)
    ) u_bank (
        .clk     (clk),
        .rstn    (rstn),
        .inc_en  (!in_dump && sample && in_rng),
        .inc_idx (IDX_W'(noise_in - NOISE_OFS)),
        .clr_en  (in_dump),
        .word_idx(word_cnt),
        .rd_word (rd_word)
    );

    // Port outputs decode straight from state so a reset drops mem_wen at once.
    assign busy          = in_dump;
    assign mem_wen       = in_dump;
    assign mem_addr      = in_dump ? base_q + ADDR_W'(word_cnt) : '0;
    assign mem_writedata = in_dump ? 64'(rd_word) : '0;

endmodule

// File: doc/noise_hist_ocm_writer.md
NOISE_HIST_OCM_WRITER -- requirements
Module: noise_hist_ocm_writer

Interface
REQ-001 Parameter NBINS, default 128, number of histogram bins covering signed noise values -64..+63.
REQ-002 Parameter CNT_W, default 16, width of each bin counter.
REQ-003 Parameter ADDR_W, default 14, word-address width of the 64-bit OCM write port.
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 rstn  input  1  reset, asynchronous assert, active-low.
REQ-006 en  input  1  block enable; when low no sample is counted and dump_start is ignored.
REQ-007 noise_in  input  8  signed noise sample, the noise_out of the noise generator.
REQ-008 noise_in_valid  input  1  noise_in qualifier, one sample per high cycle.
REQ-009 dump_start  input  1  single-cycle request to write the histogram to OCM.
REQ-010 base_addr  input  ADDR_W  OCM word address of bin word 0, sampled on accepted dump_start.
REQ-011 mem_addr  output  ADDR_W  OCM 64-bit port address.
REQ-012 mem_wen  output  1  OCM 64-bit port write enable.
REQ-013 mem_writedata  output  64  OCM 64-bit port write data.
REQ-014 busy  output  1  high while in DUMP.
REQ-015 done  output  1  one-cycle pulse after the last word is written.
REQ-016 oor_flag  output  1  sticky: a sample outside -64..+63 was received.
REQ-017 drop_flag  output  1  sticky: a valid sample arrived during DUMP and was discarded.

Function
REQ-018 States ACCUM and DUMP only; reset enters ACCUM.
REQ-019 ACCUM: en && noise_in_valid && -64 <= noise_in <= 63 increments bin[noise_in + 64] by 1 the next cycle.
REQ-020 Bin counters saturate at 2^CNT_W-1; no wrap to zero.
REQ-021 A valid sample outside -64..+63 updates no bin and sets oor_flag.
REQ-022 ACCUM with en && dump_start: latch base_addr, go to DUMP next cycle; a valid sample in that same cycle is counted first.
REQ-023 DUMP writes NBINS/4 = 32 words, one per cycle, no gaps: word k at mem_addr = base_addr + k, mem_wen = 1.
REQ-024 Word k packing: bits [16j+15:16j] = bin[4k+j], j = 0..3 (bin 0 = value -64 in bits [15:0] of word 0).
REQ-025 Address wraps modulo 2^ADDR_W if base_addr + k overflows.
REQ-026 Each bin clears to 0 in the cycle its word is written; histogram is empty after DUMP.
REQ-027 First write occurs the cycle after dump_start is accepted; done pulses the cycle after word 31 (latency 33 cycles dump_start to done); state returns to ACCUM with done.
REQ-028 dump_start during DUMP is ignored; valid samples during DUMP are dropped and set drop_flag.
REQ-029 oor_flag and drop_flag clear only on reset or on accepted dump_start (cleared the cycle DUMP starts).
REQ-030 Outside DUMP, mem_wen = 0, mem_addr and mem_writedata hold 0.

Reset
REQ-031 rstn low asynchronously forces ACCUM, all bins 0, mem_wen/mem_addr/mem_writedata 0, busy/done/oor_flag/drop_flag 0.
REQ-032 Reset mid-DUMP aborts immediately; no further writes after rstn falls; partially written OCM contents are not restored.

Structure
REQ-033 Package noise_hist_pkg holds the state enum (ACCUM, DUMP), NOISE_MIN = -64, NOISE_MAX = 63, BINS_PER_WORD = 4.
REQ-034 One sub-module noise_hist_bank: NBINS saturating counters with increment index, read-and-clear word index, 64-bit packed read.

Verification
REQ-035 Reset, feed 10 valid samples of +5, dump_start with base_addr 0x100 -> 32 writes to 0x100..0x11F; word 0x111 bits [31:16] = 10; all other fields 0; done 33 cycles after dump_start.
REQ-036 Samples -64 x3, +63 x2, +70 x1, dump -> word 0 bits [15:0] = 3, word 31 bits [63:48] = 2, oor_flag = 1 before dump, 0 after.
REQ-037 70000 samples of 0 then dump -> bin 64 field (word 16 bits [15:0]) = 65535 (saturated).
REQ-038 Valid sample and dump_start same cycle -> sample counted; samples during DUMP not counted, drop_flag = 1; second dump writes all-zero words.
REQ-039 base_addr 0x3FF0 -> addresses 0x3FF0..0x3FFF then 0x0000..0x000F.
REQ-040 rstn low at word 10 of DUMP -> mem_wen 0 immediately, state ACCUM, subsequent dump writes all zeros.
